// File: rtl/r_resp_buffer_sf_if.sv
// R-channel beat bus between the AXI slave side and the ordering unit.
// The master side offers beats on in_* and consumes the head on out_*;
// the slave side is the buffer itself.
interface r_resp_buffer_sf_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ID_WIDTH-1:0]   in_id;
  logic [DATA_WIDTH-1:0] in_data;
  logic [RESP_WIDTH-1:0] in_resp;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DATA_WIDTH-1:0] out_data;
  logic [RESP_WIDTH-1:0] out_resp;
  logic                  out_last;

  modport master (
    output in_valid, in_id, in_data, in_resp, in_last, out_ready,
    input  in_ready, out_valid, out_id, out_data, out_resp, out_last
  );

  modport slave (
    input  in_valid, in_id, in_data, in_resp, in_last, out_ready,
    output in_ready, out_valid, out_id, out_data, out_resp, out_last
  );
endinterface

// File: rtl/r_resp_buffer_sf.sv
// R-beat circular FIFO with optional per-burst store-and-forward release.
// Exports occupancy, the number of resident burst-terminating beats and an
// almost-full flag. in_ready depends only on registered state, and the head
// is read straight from memory with no write-to-read bypass.
module r_resp_buffer_sf #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int DEPTH      = 8,
  parameter int STORE_FWD  = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  r_resp_buffer_sf_if.slave   bus,
  output logic [CNT_W-1:0]    occupancy,
  output logic [CNT_W-1:0]    bursts_stored,
  output logic                almost_full
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;

  generate
    if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_params
      $error("r_resp_buffer_sf: DEPTH must be >= 2 and AF_THRESH within 1..DEPTH");
    end
  endgenerate

  logic [BEAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              in_burst;
  logic              full;
  logic              empty;
  logic              release_ok;
  logic              push;
  logic              pop;
  logic              inc_burst;
  logic              dec_burst;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (occupancy == CNT_W'(DEPTH));
  assign empty = (occupancy == '0);

  assign {bus.out_id, bus.out_data, bus.out_resp, bus.out_last} = mem[rd_ptr];

  // Store-and-forward releases the head when a whole burst is resident, when
  // the buffer is full (a burst longer than DEPTH would otherwise deadlock),
  // or when the head burst has already started leaving.
  assign release_ok    = (STORE_FWD == 0) | (bursts_stored != '0) | full | in_burst;
  assign bus.in_ready  = ~rst & ~full;
  assign bus.out_valid = ~rst & ~empty & release_ok;
  assign almost_full   = ~rst & (occupancy >= CNT_W'(AF_THRESH));

  assign push      = bus.in_valid & bus.in_ready;
  assign pop       = bus.out_valid & bus.out_ready;
  assign inc_burst = push & bus.in_last;
  assign dec_burst = pop & bus.out_last;

  // Payload storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_id, bus.in_data, bus.in_resp, bus.in_last};
    end
  end

  // Pointers, counters and the head-burst tracking flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      bursts_stored <= '0;
      in_burst      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= next_ptr(rd_ptr);
        in_burst <= ~bus.out_last;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      case ({inc_burst, dec_burst})
        2'b10:   bursts_stored <= bursts_stored + CNT_W'(1);
        2'b01:   bursts_stored <= bursts_stored - CNT_W'(1);
        default: bursts_stored <= bursts_stored;
      endcase
    end
  end

endmodule

// File: tb/tb_r_resp_buffer_sf.sv
// Bench for r_resp_buffer_sf: a cut-through instance (DEPTH=5, AF_THRESH=3)
// and a store-and-forward instance (DEPTH=6, AF_THRESH=4) share clk/rst and
// are compared against a queue-based model of the buffer's release rules.
module tb_r_resp_buffer_sf;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk;
  logic rst;

  logic        in_valid  [2];
  logic [3:0]  in_id     [2];
  logic [63:0] in_data   [2];
  logic [1:0]  in_resp   [2];
  logic        in_last   [2];
  logic        out_ready [2];
  logic        i_ready   [2];
  logic        o_valid   [2];
  logic [3:0]  o_id      [2];
  logic [63:0] o_data    [2];
  logic [1:0]  o_resp    [2];
  logic        o_last    [2];
  logic [2:0]  occ       [2];
  logic [2:0]  bst       [2];
  logic        af        [2];

  int depth_c [2] = '{5, 6};
  int sf_c    [2] = '{0, 1};
  int af_c    [2] = '{3, 4};

  beat_t mq  [2][$];
  bit    mib [2];

  int checks   = 0;
  int failures = 0;

  r_resp_buffer_sf_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) if0 ();
  r_resp_buffer_sf_if #(.ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2)) if1 ();

  assign if0.in_valid  = in_valid[0];
  assign if0.in_id     = in_id[0];
  assign if0.in_data   = in_data[0];
  assign if0.in_resp   = in_resp[0];
  assign if0.in_last   = in_last[0];
  assign if0.out_ready = out_ready[0];
  assign i_ready[0]    = if0.in_ready;
  assign o_valid[0]    = if0.out_valid;
  assign o_id[0]       = if0.out_id;
  assign o_data[0]     = if0.out_data;
  assign o_resp[0]     = if0.out_resp;
  assign o_last[0]     = if0.out_last;

  assign if1.in_valid  = in_valid[1];
  assign if1.in_id     = in_id[1];
  assign if1.in_data   = in_data[1];
  assign if1.in_resp   = in_resp[1];
  assign if1.in_last   = in_last[1];
  assign if1.out_ready = out_ready[1];
  assign i_ready[1]    = if1.in_ready;
  assign o_valid[1]    = if1.out_valid;
  assign o_id[1]       = if1.out_id;
  assign o_data[1]     = if1.out_data;
  assign o_resp[1]     = if1.out_resp;
  assign o_last[1]     = if1.out_last;

  r_resp_buffer_sf #(
    .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2),
    .DEPTH(5), .STORE_FWD(0), .AF_THRESH(3)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave),
    .occupancy(occ[0]), .bursts_stored(bst[0]), .almost_full(af[0])
  );

  r_resp_buffer_sf #(
    .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2),
    .DEPTH(6), .STORE_FWD(1), .AF_THRESH(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .occupancy(occ[1]), .bursts_stored(bst[1]), .almost_full(af[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_bursts(input int d);
    int n = 0;
    foreach (mq[d][i]) if (mq[d][i].last) n++;
    return n;
  endfunction

  function automatic bit m_valid(input int d);
    int n = mq[d].size();
    if (rst || n == 0) return 1'b0;
    if (sf_c[d] == 0) return 1'b1;
    return (m_bursts(d) != 0) || (n == depth_c[d]) || mib[d];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive(input int d, input logic v, input logic [3:0] id,
                       input logic [63:0] data, input logic [1:0] resp,
                       input logic last, input logic rdy);
    in_valid[d]  = v;
    in_id[d]     = id;
    in_data[d]   = data;
    in_resp[d]   = resp;
    in_last[d]   = last;
    out_ready[d] = rdy;
  endtask

  // Advance one clock and apply the handshake outcome to the model.
  task automatic step(input int d);
    bit    do_push;
    bit    do_pop;
    beat_t b;
    beat_t h;
    #1;
    do_push = in_valid[d] && (mq[d].size() < depth_c[d]);
    do_pop  = m_valid(d) && out_ready[d];
    b.id = in_id[d]; b.data = in_data[d]; b.resp = in_resp[d]; b.last = in_last[d];
    @(posedge clk);
    if (do_pop) begin
      h = mq[d].pop_front();
      mib[d] = !h.last;
    end
    if (do_push) mq[d].push_back(b);
    #1;
  endtask

  // Empty the buffer, closing any open burst so store-and-forward releases it.
  task automatic drain(input int d);
    for (int i = 0; i < 40; i++) begin
      if (mq[d].size() == 0) break;
      drive(d, !m_valid(d) && (mq[d].size() < depth_c[d]), 4'hf, rnd64(), 2'b00, 1'b1, 1'b1);
      step(d);
    end
    drive(d, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) drive(d, 1'b1, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (i_ready[d] !== 1'b0) begin failures++; $display("FAIL reset_in_ready d=%0d got=%b want=0", d, i_ready[d]); end
      checks++; if (o_valid[d] !== 1'b0) begin failures++; $display("FAIL reset_out_valid d=%0d got=%b want=0", d, o_valid[d]); end
      checks++; if (af[d] !== 1'b0) begin failures++; $display("FAIL reset_almost_full d=%0d got=%b want=0", d, af[d]); end
      checks++; if (occ[d] !== 3'd0) begin failures++; $display("FAIL reset_occupancy d=%0d got=%0d want=0", d, occ[d]); end
      checks++; if (bst[d] !== 3'd0) begin failures++; $display("FAIL reset_bursts d=%0d got=%0d want=0", d, bst[d]); end
      drive(d, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (i_ready[d] !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready d=%0d got=%b want=1", d, i_ready[d]); end
    end
  endtask

  task automatic test_in_order();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1'b1, 4'(i), rnd64(), 2'(i), 1'b1, 1'b0);
      step(0);
    end
    drive(0, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checks++; if (occ[0] !== 3'd3) begin failures++; $display("FAIL order_occupancy got=%0d want=3", occ[0]); end
    checks++; if (bst[0] !== 3'd3) begin failures++; $display("FAIL order_bursts got=%0d want=3", bst[0]); end
    drive(0, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++; if (o_valid[0] !== 1'b1 || o_id[0] !== 4'(i) || o_data[0] !== mq[0][0].data)
        begin failures++; $display("FAIL order_beat%0d got v=%b id=%0d want v=1 id=%0d", i, o_valid[0], o_id[0], i); end
      step(0);
    end
    #1;
    checks++; if (occ[0] !== 3'd0 || o_valid[0] !== 1'b0) begin failures++; $display("FAIL order_empty got occ=%0d v=%b want 0/0", occ[0], o_valid[0]); end
    drive(0, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 4'($urandom), rnd64(), 2'($urandom), 1'($urandom), 1'b0);
      step(0);
    end
    drive(0, 1'b1, 4'h9, 64'h0bad_0bad_0bad_0bad, 2'b00, 1'b1, 1'b1);
    #1;
    checks++; if (occ[0] !== 3'd5) begin failures++; $display("FAIL full_occupancy got=%0d want=5", occ[0]); end
    checks++; if (i_ready[0] !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b want=0", i_ready[0]); end
    checks++; if (af[0] !== 1'b1) begin failures++; $display("FAIL full_almost_full got=%b want=1", af[0]); end
    step(0);
    #1;
    checks++; if (occ[0] !== 3'd4) begin failures++; $display("FAIL full_push_pop_occupancy got=%0d want=4", occ[0]); end
    checks++; if (i_ready[0] !== 1'b1) begin failures++; $display("FAIL after_full_in_ready got=%b want=1", i_ready[0]); end
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'b1, 4'($urandom), rnd64(), 2'($urandom), 1'($urandom), 1'b1);
      #1;
      checks++; if (o_valid[0] !== 1'b1 || {o_id[0], o_data[0], o_resp[0], o_last[0]} !== mq[0][0])
        begin failures++; $display("FAIL wrap_beat%0d got id=%0d data=%h want id=%0d data=%h", i, o_id[0], o_data[0], mq[0][0].id, mq[0][0].data); end
      step(0);
    end
    drive(0, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    while (mq[0].size() > 0) begin
      #1;
      checks++; if ({o_id[0], o_data[0], o_resp[0], o_last[0]} !== mq[0][0])
        begin failures++; $display("FAIL wrap_drain got data=%h want=%h", o_data[0], mq[0][0].data); end
      step(0);
    end
    drive(0, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_store_fwd();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 4'(i + 4), rnd64(), 2'b10, (i == 3), 1'b1);
      step(1);
      #1;
      checks++; if (o_valid[1] !== (i == 3)) begin failures++; $display("FAIL sf_hold_beat%0d got=%b want=%b", i, o_valid[1], (i == 3)); end
    end
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o_valid[1] !== 1'b1 || o_id[1] !== 4'(i + 4) || o_last[1] !== (i == 3) || o_resp[1] !== 2'b10)
        begin failures++; $display("FAIL sf_pop%0d got v=%b id=%0d last=%b want v=1 id=%0d last=%b", i, o_valid[1], o_id[1], o_last[1], i + 4, (i == 3)); end
      step(1);
    end
    #1;
    checks++; if (o_valid[1] !== 1'b0 || bst[1] !== 3'd0) begin failures++; $display("FAIL sf_end got v=%b bursts=%0d want 0/0", o_valid[1], bst[1]); end
  endtask

  task automatic test_long_burst();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b1, 4'(i), rnd64(), 2'b00, 1'b0, 1'b0);
      step(1);
    end
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checks++; if (o_valid[1] !== 1'b1 || bst[1] !== 3'd0) begin failures++; $display("FAIL long_full_escape got v=%b bursts=%0d want 1/0", o_valid[1], bst[1]); end
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    step(1);
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checks++; if (o_valid[1] !== 1'b1 || occ[1] !== 3'd5) begin failures++; $display("FAIL long_in_burst got v=%b occ=%0d want 1/5", o_valid[1], occ[1]); end
    for (int i = 6; i < 8; i++) begin
      drive(1, 1'b1, 4'(i), rnd64(), 2'b00, (i == 7), 1'b1);
      #1;
      checks++; if (o_valid[1] !== 1'b1 || o_id[1] !== mq[1][0].id) begin failures++; $display("FAIL long_stream%0d got v=%b id=%0d want 1/%0d", i, o_valid[1], o_id[1], mq[1][0].id); end
      step(1);
    end
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 8 && mq[1].size() > 0; i++) begin
      #1;
      checks++; if (o_valid[1] !== 1'b1 || o_id[1] !== mq[1][0].id) begin failures++; $display("FAIL long_drain got v=%b id=%0d want 1/%0d", o_valid[1], o_id[1], mq[1][0].id); end
      step(1);
    end
    #1;
    checks++; if (occ[1] !== 3'd0 || bst[1] !== 3'd0) begin failures++; $display("FAIL long_end got occ=%0d bursts=%0d want 0/0", occ[1], bst[1]); end
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_simul_push_pop();
    drive(0, 1'b1, 4'h3, rnd64(), 2'b01, 1'b1, 1'b0);
    step(0);
    drive(0, 1'b1, 4'h4, rnd64(), 2'b00, 1'b1, 1'b1);
    step(0);
    drive(0, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checks++; if (occ[0] !== 3'd1 || bst[0] !== 3'd1) begin failures++; $display("FAIL simul_counts got occ=%0d bursts=%0d want 1/1", occ[0], bst[0]); end
    checks++; if (o_id[0] !== 4'h4) begin failures++; $display("FAIL simul_head got id=%0d want 4", o_id[0]); end
    drain(0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 4'(i), rnd64(), 2'b00, 1'b0, 1'b0);
      step(0);
    end
    drive(0, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b1, 4'(i), rnd64(), 2'b00, 1'b0, 1'b0);
      step(1);
    end
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b1);
    step(1);
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checks++; if (occ[0] !== 3'd3 || o_valid[0] !== 1'b1) begin failures++; $display("FAIL midrst_pre got occ=%0d v=%b want 3/1", occ[0], o_valid[0]); end
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_valid[d] !== 1'b0 || i_ready[d] !== 1'b0) begin failures++; $display("FAIL midrst_async d=%0d got v=%b rdy=%b want 0/0", d, o_valid[d], i_ready[d]); end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mib[d] = 1'b0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (occ[d] !== 3'd0 || o_valid[d] !== 1'b0 || bst[d] !== 3'd0) begin failures++; $display("FAIL midrst_post d=%0d got occ=%0d v=%b bursts=%0d want 0/0/0", d, occ[d], o_valid[d], bst[d]); end
    end
    drive(1, 1'b1, 4'h7, rnd64(), 2'b00, 1'b0, 1'b0);
    step(1);
    drive(1, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    #1;
    checks++; if (o_valid[1] !== 1'b0) begin failures++; $display("FAIL midrst_in_burst_cleared got v=%b want 0", o_valid[1]); end
    drain(1);
  endtask

  task automatic test_random();
    beat_t got;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 300; c++) begin
        drive(d, ($urandom_range(0, 3) != 0), 4'($urandom), rnd64(), 2'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        #1;
        got = {o_id[d], o_data[d], o_resp[d], o_last[d]};
        checks++; if (i_ready[d] !== (mq[d].size() < depth_c[d])) begin failures++; $display("FAIL rnd_in_ready d=%0d c=%0d got=%b want=%b", d, c, i_ready[d], (mq[d].size() < depth_c[d])); end
        checks++; if (o_valid[d] !== m_valid(d)) begin failures++; $display("FAIL rnd_out_valid d=%0d c=%0d got=%b want=%b", d, c, o_valid[d], m_valid(d)); end
        checks++; if (occ[d] !== 3'(mq[d].size())) begin failures++; $display("FAIL rnd_occupancy d=%0d c=%0d got=%0d want=%0d", d, c, occ[d], mq[d].size()); end
        checks++; if (bst[d] !== 3'(m_bursts(d))) begin failures++; $display("FAIL rnd_bursts d=%0d c=%0d got=%0d want=%0d", d, c, bst[d], m_bursts(d)); end
        checks++; if (af[d] !== (mq[d].size() >= af_c[d])) begin failures++; $display("FAIL rnd_almost_full d=%0d c=%0d got=%b want=%b", d, c, af[d], (mq[d].size() >= af_c[d])); end
        if (m_valid(d)) begin
          checks++; if (got !== mq[d][0]) begin failures++; $display("FAIL rnd_head d=%0d c=%0d got=%h want=%h", d, c, got, mq[d][0]); end
        end
        step(d);
      end
      drain(d);
      #1;
      checks++; if (occ[d] !== 3'd0) begin failures++; $display("FAIL rnd_drained d=%0d got=%0d want=0", d, occ[d]); end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mib[d] = 1'b0;
      drive(d, 1'b0, 4'h0, 64'h0, 2'b00, 1'b0, 1'b0);
    end
    test_reset();
    test_in_order();
    test_full_wrap();
    test_store_fwd();
    test_long_burst();
    test_simul_push_pop();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
